// File: rtl/sts_snapshot.sv
// sts_snapshot: freezes a wide live status vector into a coherent snapshot
// on a trigger rising edge or a programmable period, and prepends a header
// word {seq[15:0], 12'b0, frozen, timeout, missed, valid} for the status block.
// Optional macro STS_SNAPSHOT_TIMESTAMP_EN adds a second header word that
// holds a free-running cycle count latched on each capture.
module sts_snapshot #(
    parameter int unsigned STS_DATA_WIDTH = 1024,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 1024,
    parameter int unsigned PERIOD_WIDTH   = 32,
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
    localparam int unsigned HDR_WORDS     = 2,
`else
    localparam int unsigned HDR_WORDS     = 1,
`endif
    localparam int unsigned LIVE_WIDTH    = STS_DATA_WIDTH - HDR_WORDS * 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [LIVE_WIDTH-1:0]     live_data,
    input  logic                      live_valid,
    input  logic                      trig,
    input  logic [PERIOD_WIDTH-1:0]   period_cfg,
    input  logic                      freeze,
    input  logic                      clear,
    output logic                      busy,
    output logic [STS_DATA_WIDTH-1:0] sts_data
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    trig_q;
    logic [PERIOD_WIDTH-1:0] per_cnt_q;
    logic [PERIOD_WIDTH-1:0] per_cnt_d;
    logic [TW-1:0]           tcnt_q;
    logic [15:0]             seq_q;
    logic                    valid_q;
    logic                    missed_q;
    logic                    timeout_q;
    logic                    frozen_q;
    logic [LIVE_WIDTH-1:0]   live_q;
    logic                    trig_evt;
    logic                    per_evt;
    logic                    evt;
    logic [AXI_DATA_WIDTH-1:0] hdr_word;

`ifdef STS_SNAPSHOT_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_cap_q;
`endif

    // Event decode: trigger rising edge merged with the periodic tick.
    always_comb begin
        trig_evt  = trig & ~trig_q;
        per_evt   = 1'b0;
        per_cnt_d = '0;
        if (period_cfg != '0) begin
            // >= so that shrinking period_cfg takes effect on the next edge
            if (per_cnt_q >= period_cfg - PERIOD_WIDTH'(1)) begin
                per_evt = 1'b1;
            end else begin
                per_cnt_d = per_cnt_q + PERIOD_WIDTH'(1);
            end
        end
        evt = trig_evt | per_evt;
    end

    // Free-running counters: trigger history, period counter, timestamp.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            trig_q    <= 1'b0;
            per_cnt_q <= '0;
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            trig_q    <= trig;
            per_cnt_q <= per_cnt_d;
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
            ts_q      <= ts_q + 32'd1;
`endif
        end
    end

    // Capture FSM; flags and data update on the same edge so seq never lags data.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            tcnt_q    <= '0;
            seq_q     <= '0;
            valid_q   <= 1'b0;
            missed_q  <= 1'b0;
            timeout_q <= 1'b0;
            frozen_q  <= 1'b0;
            live_q    <= '0;
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
            ts_cap_q  <= '0;
`endif
        end else begin
            frozen_q  <= freeze;
            // Default clear; a later set in this block overrides it.
            missed_q  <= missed_q & ~clear;
            timeout_q <= timeout_q & ~clear;
            unique case (state_q)
                StIdle: begin
                    if (evt) begin
                        if (freeze) begin
                            missed_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            busy_q  <= 1'b1;
                            tcnt_q  <= '0;
                        end
                    end
                end
                StWait: begin
                    // Events while a capture is pending are dropped.
                    if (evt) begin
                        missed_q <= 1'b1;
                    end
                    if (freeze) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        missed_q <= 1'b1;
                    end else if (live_valid) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        live_q  <= live_data;
                        seq_q   <= seq_q + 16'd1;
                        valid_q <= 1'b1;
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
                        ts_cap_q <= ts_q + 32'd1;
`endif
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output assembly from registers only.
    always_comb begin
        hdr_word = {seq_q, 12'h000, frozen_q, timeout_q, missed_q, valid_q};
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
        sts_data = {live_q, ts_cap_q, hdr_word};
`else
        sts_data = {live_q, hdr_word};
`endif
        busy     = busy_q;
    end

endmodule

// File: tb/tb_sts_snapshot.sv
// Self-checking bench for sts_snapshot: directed scenarios plus randomized
// stimulus, compared every cycle against a behavioural model.
module tb_sts_snapshot;

    localparam int SW = 128;
    localparam int TO = 12;
    localparam int PW = 8;
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
    localparam int HW = 2;
`else
    localparam int HW = 1;
`endif
    localparam int LW = SW - HW * 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [LW-1:0] live_data = '0;
    logic          live_valid = 1'b0;
    logic          trig = 1'b0;
    logic [PW-1:0] period_cfg = '0;
    logic          freeze = 1'b0;
    logic          clear = 1'b0;
    logic          busy;
    logic [SW-1:0] sts_data;

    int checks = 0;
    int errors = 0;

    sts_snapshot #(
        .STS_DATA_WIDTH (SW),
        .AXI_DATA_WIDTH (32),
        .TIMEOUT        (TO),
        .PERIOD_WIDTH   (PW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .live_data  (live_data),
        .live_valid (live_valid),
        .trig       (trig),
        .period_cfg (period_cfg),
        .freeze     (freeze),
        .clear      (clear),
        .busy       (busy),
        .sts_data   (sts_data)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: pending-capture flag, wait count and snapshot contents.
    bit            m_trig_prev, m_pending, m_valid, m_missed, m_tout, m_frozen;
    int            m_pcnt, m_wcnt;
    logic [15:0]   m_seq;
    logic [31:0]   m_ts, m_ts_cap;
    logic [LW-1:0] m_live;

    always @(posedge aclk) begin : model
        bit te, pe, ev, sm, st;
        if (!aresetn) begin
            m_trig_prev = 0; m_pending = 0; m_valid = 0; m_missed = 0;
            m_tout = 0; m_frozen = 0; m_pcnt = 0; m_wcnt = 0;
            m_seq = '0; m_ts = '0; m_ts_cap = '0; m_live = '0;
        end else begin
            te = trig && !m_trig_prev;
            m_trig_prev = trig;
            pe = 0;
            if (period_cfg == '0) m_pcnt = 0;
            else if (m_pcnt + 1 >= int'(period_cfg)) begin
                pe = 1;
                m_pcnt = 0;
            end else m_pcnt++;
            ev = te || pe;
            sm = 0;
            st = 0;
            m_ts = m_ts + 32'd1;
            if (!m_pending) begin
                if (ev && freeze) sm = 1;
                else if (ev) begin
                    m_pending = 1;
                    m_wcnt = 0;
                end
            end else begin
                if (ev) sm = 1;
                if (freeze) begin
                    m_pending = 0;
                    sm = 1;
                end else if (live_valid) begin
                    m_pending = 0;
                    m_live = live_data;
                    m_seq = m_seq + 16'd1;
                    m_valid = 1;
                    m_ts_cap = m_ts;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_pending = 0;
                        st = 1;
                    end
                end
            end
            m_missed = sm || (m_missed && !clear);
            m_tout = st || (m_tout && !clear);
            m_frozen = freeze;
        end
    end

    function automatic logic [SW-1:0] m_expect();
        logic [31:0] hdr;
        hdr = {m_seq, 12'h000, m_frozen, m_tout, m_missed, m_valid};
`ifdef STS_SNAPSHOT_TIMESTAMP_EN
        return {m_live, m_ts_cap, hdr};
`else
        return {m_live, hdr};
`endif
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge aclk) begin
        check("busy", SW'(busy), SW'(m_pending));
        check("sts_data", sts_data, m_expect());
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    initial begin
        logic [LW-1:0]  pat;
        logic [127:0]   r;
        pat = {(LW / 8){8'hA5}};

        tick(3);
        aresetn = 1'b1;
        tick(10);
        check("idle_sts", sts_data, SW'(0));
        check("idle_busy", SW'(busy), SW'(0));

        // Single trigger with live data already valid.
        live_valid = 1'b1;
        live_data  = pat;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check("trig_busy", SW'(busy), SW'(1));
        tick(1);
        check("trig_busy_end", SW'(busy), SW'(0));
        check("trig_hdr", SW'(sts_data[31:0]), SW'(32'h0001_0001));
        check("trig_live", SW'(sts_data[SW-1 -: LW]), SW'(pat));

        // Periodic capture every 8 cycles: 5 more captures.
        period_cfg = 8'd8;
        tick(42);
        period_cfg = '0;
        check("period_seq", SW'(sts_data[31:16]), SW'(16'd6));

        // Timeout with live_valid low.
        live_valid = 1'b0;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(TO + 1);
        check("tout_busy", SW'(busy), SW'(0));
        check("tout_flag", SW'(sts_data[2]), SW'(1));
        check("tout_seq", SW'(sts_data[31:16]), SW'(16'd6));
        check("tout_live", SW'(sts_data[SW-1 -: LW]), SW'(pat));
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("tout_clear", SW'(sts_data[2]), SW'(0));

        // Trigger while frozen.
        freeze = 1'b1;
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        check("frz_missed", SW'(sts_data[1]), SW'(1));
        check("frz_frozen", SW'(sts_data[3]), SW'(1));
        check("frz_busy", SW'(busy), SW'(0));
        freeze = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("miss_clear", SW'(sts_data[1]), SW'(0));

        // Second trigger edge while waiting: one capture, missed set.
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(1);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        live_valid = 1'b1;
        tick(1);
        live_valid = 1'b0;
        tick(3);
        check("wait_seq", SW'(sts_data[31:16]), SW'(16'd7));
        check("wait_missed", SW'(sts_data[1]), SW'(1));

`ifdef STS_SNAPSHOT_TIMESTAMP_EN
        // Timestamp: trigger event at edge 100 after reset, capture at 101.
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        live_valid = 1'b1;
        tick(99);
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
        tick(1);
        check("ts_word", SW'(sts_data[63:32]), SW'(32'd101));
`endif

        // Randomized phase, with sparse-valid windows to provoke timeouts.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) period_cfg = PW'($urandom_range(0, 12));
            trig       = ($urandom_range(0, 3) == 0);
            if ((i / 250) % 2 == 1) live_valid = ($urandom_range(0, 9) == 0);
            else live_valid = ($urandom_range(0, 2) != 0);
            freeze     = ($urandom_range(0, 15) == 0);
            clear      = ($urandom_range(0, 9) == 0);
            aresetn    = ($urandom_range(0, 499) != 0);
            r = {$urandom, $urandom, $urandom, $urandom};
            live_data  = r[LW-1:0];
            tick(1);
        end
        aresetn = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
